// File: rtl/intc_pkg.sv
// intc_pkg: register map, FSM state type and the "no vector" code shared by the interrupt controller.
package intc_pkg;
    localparam logic [2:0] ADDR_SEL     = 3'd0;
    localparam logic [2:0] ADDR_ENABLE  = 3'd1;
    localparam logic [2:0] ADDR_TYPE    = 3'd2;
    localparam logic [2:0] ADDR_PENDING = 3'd3;
    localparam logic [2:0] ADDR_VECTOR  = 3'd4;
    localparam logic [2:0] ADDR_EOI     = 3'd5;
    localparam logic [2:0] ADDR_STATUS  = 3'd6;
    localparam logic [7:0] VECTOR_NONE  = 8'hFF;
    typedef enum logic {IDLE = 1'b0, SERVICE = 1'b1} state_t;
endpackage

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: fixed-priority encoder, lowest set index wins.
module intc_prio_enc #(
    parameter int NUM_IRQ = 32
) (
    input  logic [NUM_IRQ-1:0] i_req,
    output logic [7:0]         o_idx,
    output logic               o_valid
);
    always_comb begin
        o_idx = 8'h00;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (i_req[i]) o_idx = 8'(i);
    end
    assign o_valid = |i_req;
endmodule

// File: rtl/priority_interrupt_controller.sv
// priority_interrupt_controller: byte-windowed fixed-priority interrupt controller with VECTOR/EOI handshake.
// Define INTC_INPUT_SYNC_EN to pass int_in through two-flop synchronisers.
module priority_interrupt_controller
    import intc_pkg::*;
#(
    parameter int NUM_IRQ   = 32,
    parameter int SEL_WIDTH = $clog2(NUM_IRQ / 8)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         i_data,
    output logic [7:0]         o_data,
    input  logic [2:0]         addr,
    input  logic               cs,
    input  logic               rwb,
    input  logic [NUM_IRQ-1:0] int_in,
    output logic               int_out
);
    localparam int NB = NUM_IRQ / 8;
    localparam int SW = (SEL_WIDTH < 1) ? 1 : SEL_WIDTH;

    logic [SW-1:0]      r_sel;
    logic [NUM_IRQ-1:0] r_enable, r_type, r_epend, r_prev;
    logic [NUM_IRQ-1:0] w_in, w_pend, w_set, w_clr, w_win, w_wdat;
    logic [SW+2:0]      w_off;
    logic [7:0]         w_idx;
    logic               w_any, w_wr, w_ack, w_eoi, w_sel_ok;
    state_t             r_state;
    logic               r_int;

`ifdef INTC_INPUT_SYNC_EN
    logic [NUM_IRQ-1:0] r_sync1, r_sync2;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= int_in;
            r_sync2 <= r_sync1;
        end
    end
    assign w_in = r_sync2;
`else
    assign w_in = int_in;
`endif

    // Edge lines report the latched flag, level lines follow the input live.
    assign w_pend   = r_enable & ((r_type & r_epend) | (~r_type & w_in));
    assign w_set    = w_in & ~r_prev;
    assign w_sel_ok = int'(r_sel) < NB;
    assign w_off    = {r_sel, 3'b000};
    assign w_win    = NUM_IRQ'(8'hFF) << w_off;
    assign w_wdat   = NUM_IRQ'(i_data) << w_off;
    assign w_wr     = cs & ~rwb;
    assign w_ack    = cs & rwb & (addr == ADDR_VECTOR) & (r_state == IDLE) & w_any;
    assign w_eoi    = w_wr & (addr == ADDR_EOI) & (r_state == SERVICE);
    assign w_clr    = ((w_wr && addr == ADDR_PENDING && w_sel_ok) ? w_wdat : '0)
                    | (w_ack ? NUM_IRQ'(1) << w_idx : '0);

    intc_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_enc (
        .i_req   (w_pend),
        .o_idx   (w_idx),
        .o_valid (w_any)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel    <= '0;
            r_enable <= '0;
            r_type   <= '0;
            r_epend  <= '0;
            r_prev   <= '0;
        end else begin
            r_prev  <= w_in;
            r_epend <= r_enable & r_type & (w_set | (r_epend & ~w_clr));
            if (w_wr && addr == ADDR_SEL) r_sel <= i_data[SW-1:0];
            if (w_wr && addr == ADDR_ENABLE && w_sel_ok) r_enable <= (r_enable & ~w_win) | w_wdat;
            if (w_wr && addr == ADDR_TYPE && w_sel_ok) r_type <= (r_type & ~w_win) | w_wdat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_int   <= 1'b0;
        end else begin
            r_int   <= (r_state == IDLE) & w_any;
            r_state <= w_ack ? SERVICE : (w_eoi ? IDLE : r_state);
        end
    end

    assign int_out = r_int;
    assign o_data  = (addr == ADDR_SEL)     ? 8'(r_sel) :
                     (addr == ADDR_ENABLE)  ? (w_sel_ok ? 8'(r_enable >> w_off) : 8'h00) :
                     (addr == ADDR_TYPE)    ? (w_sel_ok ? 8'(r_type >> w_off) : 8'h00) :
                     (addr == ADDR_PENDING) ? (w_sel_ok ? 8'(w_pend >> w_off) : 8'h00) :
                     (addr == ADDR_VECTOR)  ? ((r_state == IDLE && w_any) ? w_idx : VECTOR_NONE) :
                     (addr == ADDR_STATUS)  ? {r_state == SERVICE, w_any, 6'b000000} : 8'h00;
endmodule

// File: tb/tb_priority_interrupt_controller.sv
// tb_priority_interrupt_controller: directed scenarios plus random traffic against a per-line behavioural model.
module tb_priority_interrupt_controller;
    logic        clk, rst_n, cs, rwb, int_out;
    logic [7:0]  i_data, o_data, rdv;
    logic [2:0]  addr;
    logic [31:0] int_in, irq;
    logic        io;
    int          checks, errors;

    bit [31:0] m_en, m_typ, m_ep, m_prev, m_s1, m_s2;
    bit [1:0]  m_sel;
    bit        m_svc, m_int;

    priority_interrupt_controller dut (
        .clk(clk), .reset(rst_n), .i_data(i_data), .o_data(o_data), .addr(addr),
        .cs(cs), .rwb(rwb), .int_in(int_in), .int_out(int_out)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string n, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] m_cin();
`ifdef INTC_INPUT_SYNC_EN
        return m_s2;
`else
        return irq;
`endif
    endfunction

    function automatic bit [31:0] m_pend();
        bit [31:0] c = m_cin();
        bit [31:0] p;
        for (int i = 0; i < 32; i++) p[i] = m_en[i] && (m_typ[i] ? m_ep[i] : c[i]);
        return p;
    endfunction

    function automatic int m_win();
        bit [31:0] p = m_pend();
        for (int i = 0; i < 32; i++) if (p[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] m_rd(input logic [2:0] a);
        int w = m_win();
        int sh = int'(m_sel) * 8;
        case (a)
            3'd0: return {6'b0, m_sel};
            3'd1: return 8'(m_en >> sh);
            3'd2: return 8'(m_typ >> sh);
            3'd3: return 8'(m_pend() >> sh);
            3'd4: return (!m_svc && w >= 0) ? 8'(w) : 8'hFF;
            3'd6: return {m_svc, w >= 0, 6'b0};
            default: return 8'h00;
        endcase
    endfunction

    task automatic m_reset();
        m_en = 0; m_typ = 0; m_ep = 0; m_prev = 0; m_s1 = 0; m_s2 = 0;
        m_sel = 0; m_svc = 0; m_int = 0;
    endtask

    task automatic m_step(input bit c, input bit r, input logic [2:0] a, input logic [7:0] d);
        int w = m_win();
        bit [31:0] cin = m_cin();
        bit [31:0] nep;
        bit ack = c && r && a == 3'd4 && !m_svc && w >= 0;
        bit wr = c && !r;
        for (int i = 0; i < 32; i++) begin
            bit set = cin[i] && !m_prev[i];
            bit clr = (wr && a == 3'd3 && i / 8 == int'(m_sel) && d[i % 8]) || (ack && i == w);
            nep[i] = m_en[i] && m_typ[i] && (set || (m_ep[i] && !clr));
        end
        m_int = !m_svc && w >= 0;
        if (ack) m_svc = 1;
        else if (wr && a == 3'd5) m_svc = 0;
        if (wr && a == 3'd0) m_sel = d[1:0];
        if (wr && a == 3'd1) for (int b = 0; b < 8; b++) m_en[int'(m_sel) * 8 + b] = d[b];
        if (wr && a == 3'd2) for (int b = 0; b < 8; b++) m_typ[int'(m_sel) * 8 + b] = d[b];
        m_ep = nep;
        m_prev = cin;
        m_s2 = m_s1;
        m_s1 = irq;
    endtask

    task automatic tick(input bit c, input bit r, input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = c; rwb = r; addr = a; i_data = d; int_in = irq;
        #1;
        rdv = o_data;
        io = int_out;
        check("o_data", rdv, m_rd(a));
        check("int_out", {7'b0, io}, {7'b0, m_int});
        @(posedge clk);
        m_step(c, r, a, d);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d); tick(1, 0, a, d); endtask
    task automatic rd(input logic [2:0] a); tick(1, 1, a, 8'h00); endtask
    task automatic idle(); tick(0, 1, 3'd0, 8'h00); endtask

    task automatic do_reset();
        @(negedge clk);
        cs = 0;
        rst_n = 0;
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        checks = 0; errors = 0;
        irq = 0; int_in = 0; cs = 0; rwb = 1; addr = 0; i_data = 0; rst_n = 1;
        do_reset();
        rd(3'd6); check("reset_status", rdv, 8'h00); check("reset_int_out", {7'b0, io}, 8'h00);
        rd(3'd1); check("reset_enable", rdv, 8'h00);

        // Edge line 0: pulse, acknowledge, pending clears
        wr(3'd0, 8'h00); wr(3'd1, 8'h01); wr(3'd2, 8'h01);
        irq = 32'h1; idle(); irq = 0; idle();
        rd(3'd4); check("edge0_vector", rdv, 8'h00); check("edge0_int_out", {7'b0, io}, 8'h01);
        rd(3'd3); check("edge0_pending_cleared", rdv, 8'h00);
        idle(); check("edge0_int_out_low", {7'b0, io}, 8'h00);
        wr(3'd5, 8'h00);

        // Level lines 3 and 5
        wr(3'd1, 8'h28); wr(3'd2, 8'h00);
        irq = 32'h28; idle();
        rd(3'd4); check("level_vec3", rdv, 8'h03);
        irq = 32'h20; wr(3'd5, 8'h00);
        rd(3'd4); check("level_vec5", rdv, 8'h05);
        irq = 0; wr(3'd5, 8'h00);
        rd(3'd4); check("none_vector", rdv, 8'hFF);
        rd(3'd6); check("none_status", rdv, 8'h00);

        // Edge on 9 while servicing 2
        wr(3'd1, 8'h04); wr(3'd2, 8'h04);
        wr(3'd0, 8'h01); wr(3'd1, 8'h02); wr(3'd2, 8'h02);
        irq = 32'h4; idle(); irq = 0; idle();
        rd(3'd4); check("svc_vec2", rdv, 8'h02);
        irq = 32'h200; idle(); irq = 0; idle(); idle();
        check("svc_int_out_held", {7'b0, io}, 8'h00);
        rd(3'd6); check("svc_status", rdv, 8'hC0);
        wr(3'd4, 8'h00);
        wr(3'd5, 8'h00); idle(); idle();
        check("after_eoi_int_out", {7'b0, io}, 8'h01);
        rd(3'd4); check("svc_vec9", rdv, 8'h09);
        wr(3'd5, 8'h00);

        // Same-cycle W1C and new edge on line 1
        wr(3'd0, 8'h00); wr(3'd1, 8'h02); wr(3'd2, 8'h02);
        irq = 32'h2; idle(); irq = 0; idle();
        irq = 32'h2; wr(3'd3, 8'h02);
        rd(3'd3); check("w1c_set_wins", rdv, 8'h02);
        irq = 0; wr(3'd3, 8'h02);
        rd(3'd3); check("w1c_clears", rdv, 8'h00);

        // Reset during service
        wr(3'd1, 8'h01); wr(3'd2, 8'h01);
        irq = 32'h1; idle(); irq = 0; idle();
        rd(3'd4); check("pre_reset_vec", rdv, 8'h00);
        do_reset();
        rd(3'd6); check("midsvc_status", rdv, 8'h00); check("midsvc_int_out", {7'b0, io}, 8'h00);
        rd(3'd1); check("midsvc_enable", rdv, 8'h00);

        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 3) == 0) irq = irq ^ ($urandom & $urandom);
            if ($urandom_range(0, 999) == 0) do_reset();
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/priority_interrupt_controller.md
PRIORITY_INTERRUPT_CONTROLLER -- requirements
Module: priority_interrupt_controller

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 32, number of interrupt lines (multiple of 8, 8..248).
REQ-002 SHALL have parameter SEL_WIDTH, default $clog2(NUM_IRQ/8), width of the byte-select register.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_data  input  8  CPU write data.
REQ-006 SHALL have port o_data  output  8  CPU read data, combinational from addr and state.
REQ-007 SHALL have port addr  input  3  register select.
REQ-008 SHALL have port cs  input  1  chip select, active-high.
REQ-009 SHALL have port rwb  input  1  1 = read, 0 = write.
REQ-010 SHALL have port int_in  input  NUM_IRQ  raw interrupt sources.
REQ-011 SHALL have port int_out  output  1  active-high IRQ request to the CPU.

Function
REQ-012 Register map: 0 SEL (rw), 1 ENABLE[SEL] (rw), 2 TYPE[SEL] (rw, 1 = edge, 0 = level), 3 PENDING[SEL] (r; write-1-to-clear on edge bits), 4 VECTOR (r, acknowledge), 5 EOI (w, any data), 6 STATUS (r: bit7 = in-service valid, bit6 = pending_any, bits5:0 = 0), 7 reserved (reads 0, writes ignored).
REQ-013 A write SHALL occur on each clk edge where cs=1 and rwb=0; read side effects SHALL occur on each clk edge where cs=1, rwb=1 and addr=4.
REQ-014 SEL values >= NUM_IRQ/8 SHALL read 0 from byte registers 1-3 and ignore writes.
REQ-015 Edge line i: pending[i] SHALL set one cycle after a 0->1 transition of the (conditioned) int_in[i] while enable[i]=1; it holds until W1C, acknowledge, or enable[i] cleared.
REQ-016 Level line i: pending[i] SHALL equal conditioned int_in[i] & enable[i], not latched.
REQ-017 If a set and a W1C hit the same edge bit in the same cycle, set SHALL win.
REQ-018 Priority is fixed: the lowest-indexed pending line wins; vector = its index.
REQ-019 FSM states IDLE and SERVICE; IDLE -> SERVICE on a VECTOR read while pending_any=1; SERVICE -> IDLE on an EOI write; no other transitions.
REQ-020 A VECTOR read in IDLE with pending_any=1 SHALL return the winning index, latch it as in_service, and clear that bit if it is edge type, all on the same edge.
REQ-021 A VECTOR read with pending_any=0, or in SERVICE, SHALL return 8'hFF with no state change.
REQ-022 An EOI in IDLE SHALL be ignored.
REQ-023 int_out SHALL equal (state==IDLE) & pending_any, registered (one cycle after pending changes).
REQ-024 A level line deasserted before acknowledge SHALL drop pending with no further effect.

Reset
REQ-025 On reset low: SEL, ENABLE, TYPE, PENDING, in_service, edge-history and synchroniser flops = 0; state = IDLE; int_out = 0.
REQ-026 Reset asserted mid-service SHALL abandon the service with no EOI needed.

Configuration
REQ-027 With INTC_INPUT_SYNC_EN defined, each int_in bit SHALL pass through a two-flop synchroniser before edge/level logic, adding 2 cycles to REQ-015/016 latency.
REQ-028 Without INTC_INPUT_SYNC_EN, int_in SHALL be used directly (sources assumed synchronous to clk).

Structure
REQ-029 Package intc_pkg SHALL hold register address constants, the FSM state enum, and the VECTOR_NONE = 8'hFF constant.
REQ-030 The priority encoder SHALL be a sub-module intc_prio_enc (parameter NUM_IRQ; outputs index and valid).
REQ-031 ENABLE and TYPE SHALL be full-width flop vectors written through the SEL byte window.

Verification
REQ-032 SEL=0, ENABLE=8'h01, TYPE=8'h01; pulse int_in[0] -> int_out=1 next cycle; VECTOR reads 0; int_out=0; PENDING reads 0.
REQ-033 Level lines 3 and 5 enabled and both high -> VECTOR=3; EOI; VECTOR=5 while line 5 is still high.
REQ-034 VECTOR read with nothing pending -> 8'hFF; STATUS=8'h00.
REQ-035 Edge on line 9 (SEL=1) during SERVICE of line 2 -> int_out stays 0 until EOI, then 1; VECTOR=9.
REQ-036 Same-cycle W1C and new edge on line 1 -> PENDING bit 1 remains set.
REQ-037 Reset asserted in SERVICE -> STATUS=0, int_out=0, ENABLE reads 0.
